sram_bus_arbiter: RTL and testbench

//  Shares one SRAM-like memory port (req/addr_ok/data_ok) between the IF-stage instruction requester
//  and the MEM-stage data requester. Picks a winner per address handshake, holds the grant stable

---
 rtl/sram_bus_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_sram_bus_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bus_arbiter.sv
// ---------------------------------------------------------------------------
// sram_bus_arbiter
//
// Shares one SRAM-like memory port (req / addr_ok / data_ok) between the
// IF-stage instruction requester and the MEM-stage data requester. A winner
// is picked for each address handshake and the grant is held until the
// memory accepts it. Every accepted request's source is recorded in an
// in-order FIFO, so each returning data_ok / rdata goes back to the
// requester that issued it.
//
// Parameters
//   DEPTH      max outstanding accepted-but-unanswered requests (power of 2, >=2)
//   DATA_PRIO  1: data port wins a simultaneous new request, 0: inst port wins
//
// Ports
//   clk, reset                        clock, synchronous active-high reset
//   inst_req/wr/size/wstrb/addr/wdata instruction request in
//   inst_addr_ok/data_ok/rdata        instruction handshake/response out
//   data_req/wr/size/wstrb/addr/wdata data request in
//   data_addr_ok/data_ok/rdata        data handshake/response out
//   mem_req/wr/size/wstrb/addr/wdata  merged request to memory
//   mem_addr_ok, mem_data_ok, mem_rdata  memory handshake/response in
//   outstanding                       FIFO occupancy (0..DEPTH)
//   proto_err                         sticky: data_ok arrived with FIFO empty
// ---------------------------------------------------------------------------
module sram_bus_arbiter #(
    parameter int DEPTH     = 4,
    parameter bit DATA_PRIO = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     inst_req,
    input  logic                     inst_wr,
    input  logic [1:0]               inst_size,
    input  logic [3:0]               inst_wstrb,
    input  logic [31:0]              inst_addr,
    input  logic [31:0]              inst_wdata,
    output logic                     inst_addr_ok,
    output logic                     inst_data_ok,
    output logic [31:0]              inst_rdata,

    input  logic                     data_req,
    input  logic                     data_wr,
    input  logic [1:0]               data_size,
    input  logic [3:0]               data_wstrb,
    input  logic [31:0]              data_addr,
    input  logic [31:0]              data_wdata,
    output logic                     data_addr_ok,
    output logic                     data_data_ok,
    output logic [31:0]              data_rdata,

    output logic                     mem_req,
    output logic                     mem_wr,
    output logic [1:0]               mem_size,
    output logic [3:0]               mem_wstrb,
    output logic [31:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    input  logic                     mem_addr_ok,
    input  logic                     mem_data_ok,
    input  logic [31:0]              mem_rdata,

    output logic [$clog2(DEPTH):0]   outstanding,
    output logic                     proto_err
);

    localparam int PW = $clog2(DEPTH);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HOLD_I = 2'd1;
    localparam logic [1:0] ST_HOLD_D = 2'd2;

    localparam logic [PW:0]   FULL_COUNT = (PW+1)'(DEPTH);
    localparam logic [PW:0]   CNT_ONE    = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);

    logic [1:0]    state;
    logic [1:0]    state_next;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          id_fifo [DEPTH];   // 1 = data requester, 0 = inst requester

    logic grant_data;
    logic sel_req;
    logic full;
    logic empty;
    logic push;
    logic pop;
    logic head_is_data;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

    // Grant selection: a hold state locks the grant to its owner; otherwise
    // the priority rule decides among whoever is requesting.
    always_comb begin
        grant_data = 1'b0;
        sel_req    = 1'b0;
        case (state)
            ST_HOLD_I: begin
                grant_data = 1'b0;
                sel_req    = inst_req;
            end
            ST_HOLD_D: begin
                grant_data = 1'b1;
                sel_req    = data_req;
            end
            default: begin
                if (inst_req && data_req)
                    grant_data = DATA_PRIO;
                else
                    grant_data = data_req;
                sel_req = inst_req | data_req;
            end
        endcase
    end

    // Request path is purely combinational from the granted port.
    assign mem_req   = !reset && !full && sel_req;
    assign mem_wr    = grant_data ? data_wr    : inst_wr;
    assign mem_size  = grant_data ? data_size  : inst_size;
    assign mem_wstrb = grant_data ? data_wstrb : inst_wstrb;
    assign mem_addr  = grant_data ? data_addr  : inst_addr;
    assign mem_wdata = grant_data ? data_wdata : inst_wdata;

    assign push = mem_req && mem_addr_ok;

    assign inst_addr_ok = push && !grant_data;
    assign data_addr_ok = push &&  grant_data;

    // Response routing follows the source recorded at the FIFO head.
    assign head_is_data = id_fifo[rd_ptr];
    assign pop          = !reset && mem_data_ok && !empty;

    assign inst_data_ok = pop && !head_is_data;
    assign data_data_ok = pop &&  head_is_data;
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    assign outstanding = count;

    // A request that is presented but not accepted locks the grant until
    // the memory takes it, so the address stays stable on the bus.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (mem_req && !mem_addr_ok)
                    state_next = grant_data ? ST_HOLD_D : ST_HOLD_I;
            end
            ST_HOLD_I, ST_HOLD_D: begin
                if (push)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            proto_err <= 1'b0;
        end else begin
            state <= state_next;
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (mem_data_ok && empty)
                proto_err <= 1'b1;
        end
    end

    // Source storage needs no reset: entries are only read once pushed.
    always_ff @(posedge clk) begin
        if (push)
            id_fifo[wr_ptr] <= grant_data;
    end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_bus_arbiter
//
// Self-checking bench for sram_bus_arbiter. A reference model tracks the
// locked grant owner, a queue of accepted request sources and the sticky
// protocol error, and predicts every output each cycle. Directed scenarios
// are followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_sram_bus_arbiter;

    localparam int DEPTH     = 4;
    localparam bit DATA_PRIO = 1'b1;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [3:0]  inst_wstrb;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;
    logic [2:0]  outstanding;
    logic        proto_err;

    int checks   = 0;
    int failures = 0;

    // Reference model state: 0 = no owner, 1 = inst, 2 = data.
    int lock_owner;
    bit src_q[$];
    bit model_proto;

    // Predictions for the current cycle.
    int e_owner;
    bit e_mem_req, e_iaok, e_daok, e_idok, e_ddok;

    sram_bus_arbiter #(.DEPTH(DEPTH), .DATA_PRIO(DATA_PRIO)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
        .mem_wstrb(mem_wstrb), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .outstanding(outstanding), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Let inputs settle, predict outputs from the model and compare.
    task automatic applyStimulus();
        int cnt;
        bit full;
        bit owner_req;
        #2;
        cnt  = src_q.size();
        full = (cnt == DEPTH);
        e_owner = 0; e_mem_req = 0; e_iaok = 0; e_daok = 0; e_idok = 0; e_ddok = 0;
        if (!reset) begin
            if (lock_owner != 0)           e_owner = lock_owner;
            else if (inst_req && data_req) e_owner = DATA_PRIO ? 2 : 1;
            else if (data_req)             e_owner = 2;
            else if (inst_req)             e_owner = 1;
            owner_req = (e_owner == 1) ? inst_req : (e_owner == 2) ? data_req : 1'b0;
            e_mem_req = !full && owner_req;
            e_iaok    = e_mem_req && mem_addr_ok && (e_owner == 1);
            e_daok    = e_mem_req && mem_addr_ok && (e_owner == 2);
            if (mem_data_ok && cnt > 0) begin
                e_idok = !src_q[0];
                e_ddok =  src_q[0];
            end
        end
        checkOutput("mem_req",      32'(mem_req),      32'(e_mem_req));
        checkOutput("inst_addr_ok", 32'(inst_addr_ok), 32'(e_iaok));
        checkOutput("data_addr_ok", 32'(data_addr_ok), 32'(e_daok));
        checkOutput("inst_data_ok", 32'(inst_data_ok), 32'(e_idok));
        checkOutput("data_data_ok", 32'(data_data_ok), 32'(e_ddok));
        checkOutput("outstanding",  32'(outstanding),  32'(cnt));
        checkOutput("proto_err",    32'(proto_err),    32'(model_proto));
        if (e_mem_req) begin
            checkOutput("mem_addr",  mem_addr,          (e_owner == 2) ? data_addr  : inst_addr);
            checkOutput("mem_wdata", mem_wdata,         (e_owner == 2) ? data_wdata : inst_wdata);
            checkOutput("mem_wr",    32'(mem_wr),       32'((e_owner == 2) ? data_wr    : inst_wr));
            checkOutput("mem_size",  32'(mem_size),     32'((e_owner == 2) ? data_size  : inst_size));
            checkOutput("mem_wstrb", 32'(mem_wstrb),    32'((e_owner == 2) ? data_wstrb : inst_wstrb));
        end
        if (e_idok) checkOutput("inst_rdata", inst_rdata, mem_rdata);
        if (e_ddok) checkOutput("data_rdata", data_rdata, mem_rdata);
    endtask

    // Advance the model with this cycle's events, then the clock.
    task automatic tick();
        if (reset) begin
            src_q.delete();
            lock_owner  = 0;
            model_proto = 0;
        end else begin
            if (mem_data_ok && src_q.size() == 0) model_proto = 1;
            if (e_idok || e_ddok) void'(src_q.pop_front());
            if (e_mem_req && mem_addr_ok) begin
                src_q.push_back(e_owner == 2);
                lock_owner = 0;
            end else if (e_mem_req) begin
                lock_owner = e_owner;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        applyStimulus();
        tick();
    endtask

    initial begin
        reset = 1'b1;
        inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'h0;
        inst_addr = 32'h0; inst_wdata = 32'h0;
        data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 4'hf;
        data_addr = 32'h0; data_wdata = 32'h0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 32'h0;
        lock_owner = 0; model_proto = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Reset state, with a request present that must be suppressed.
        inst_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
        applyStimulus();
        checkOutput("rst_mem_req",  32'(mem_req),      32'd0);
        checkOutput("rst_iaok",     32'(inst_addr_ok), 32'd0);
        checkOutput("rst_outst",    32'(outstanding),  32'd0);
        checkOutput("rst_proto",    32'(proto_err),    32'd0);
        tick();
        reset = 0; inst_req = 0; mem_addr_ok = 0; mem_data_ok = 0;

        // Single inst request accepted at once, response two cycles later.
        $display("[TB] single inst request");
        inst_req = 1; inst_addr = 32'h1c000000; mem_addr_ok = 1;
        applyStimulus();
        checkOutput("t1_iaok", 32'(inst_addr_ok), 32'd1);
        tick();
        inst_req = 0; mem_addr_ok = 0;
        cyc();
        mem_data_ok = 1; mem_rdata = 32'h02800c0c;
        applyStimulus();
        checkOutput("t1_idok",  32'(inst_data_ok), 32'd1);
        checkOutput("t1_ddok",  32'(data_data_ok), 32'd0);
        checkOutput("t1_rdata", inst_rdata,        32'h02800c0c);
        tick();
        mem_data_ok = 0;

        // Simultaneous requests: data wins and holds through back-pressure.
        $display("[TB] simultaneous request with hold");
        inst_req = 1; data_req = 1; inst_addr = 32'h1c000004; data_addr = 32'h80001000;
        data_wdata = 32'hcafef00d; data_wr = 1;
        for (int k = 0; k < 3; k++) begin
            applyStimulus();
            checkOutput("t2_hold_addr", mem_addr,          32'h80001000);
            checkOutput("t2_hold_iaok", 32'(inst_addr_ok), 32'd0);
            tick();
        end
        mem_addr_ok = 1;
        applyStimulus();
        checkOutput("t2_daok", 32'(data_addr_ok), 32'd1);
        checkOutput("t2_iaok", 32'(inst_addr_ok), 32'd0);
        tick();
        data_req = 0;
        applyStimulus();
        checkOutput("t2_inst_next", 32'(inst_addr_ok), 32'd1);
        tick();
        inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h11112222;
        cyc();
        cyc();
        mem_data_ok = 0;

        // Fill to DEPTH, then check no bypass on the draining cycle.
        $display("[TB] full FIFO");
        inst_req = 1; mem_addr_ok = 1;
        for (int k = 0; k < 4; k++) cyc();
        applyStimulus();
        checkOutput("t3_outst_full", 32'(outstanding), 32'd4);
        checkOutput("t3_req_full",   32'(mem_req),     32'd0);
        tick();
        mem_data_ok = 1; mem_rdata = 32'h33334444;
        applyStimulus();
        checkOutput("t3_no_bypass", 32'(mem_req), 32'd0);
        tick();
        mem_data_ok = 0;
        applyStimulus();
        checkOutput("t3_outst_after", 32'(outstanding), 32'd3);
        checkOutput("t3_req_after",   32'(mem_req),     32'd1);
        tick();
        inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
        for (int k = 0; k < 4; k++) cyc();
        mem_data_ok = 0;

        // Interleaved I, D, I responses return in order.
        $display("[TB] interleaved responses");
        mem_addr_ok = 1;
        inst_req = 1; cyc();
        inst_req = 0; data_req = 1; cyc();
        data_req = 0; inst_req = 1; cyc();
        inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
        applyStimulus(); checkOutput("t4_first_i",  32'(inst_data_ok), 32'd1); tick();
        applyStimulus(); checkOutput("t4_second_d", 32'(data_data_ok), 32'd1); tick();
        applyStimulus(); checkOutput("t4_third_i",  32'(inst_data_ok), 32'd1); tick();
        mem_data_ok = 0;

        // Push and pop together at occupancy 2.
        $display("[TB] simultaneous push and pop");
        mem_addr_ok = 1;
        inst_req = 1; cyc();
        inst_req = 0; data_req = 1; cyc();
        data_req = 0; inst_req = 1; mem_data_ok = 1;
        applyStimulus();
        checkOutput("t5_outst_pp", 32'(outstanding),  32'd2);
        checkOutput("t5_idok_pp",  32'(inst_data_ok), 32'd1);
        tick();
        inst_req = 0; mem_addr_ok = 0;
        applyStimulus();
        checkOutput("t5_outst_kept", 32'(outstanding),  32'd2);
        checkOutput("t5_head_d",     32'(data_data_ok), 32'd1);
        tick();
        applyStimulus();
        checkOutput("t5_head_i", 32'(inst_data_ok), 32'd1);
        tick();
        mem_data_ok = 0;

        // Response with nothing outstanding.
        $display("[TB] protocol error");
        mem_data_ok = 1;
        applyStimulus();
        checkOutput("t6_no_idok", 32'(inst_data_ok), 32'd0);
        checkOutput("t6_no_ddok", 32'(data_data_ok), 32'd0);
        tick();
        mem_data_ok = 0;
        applyStimulus();
        checkOutput("t6_proto_set", 32'(proto_err), 32'd1);
        tick();
        cyc();
        reset = 1; cyc();
        reset = 0;
        applyStimulus();
        checkOutput("t6_proto_clr", 32'(proto_err), 32'd0);
        tick();

        // Randomized traffic, including dropped requests and mid-run resets.
        $display("[TB] random traffic");
        for (int n = 0; n < 3000; n++) begin
            reset       = ($urandom_range(0, 99) == 0);
            inst_req    = ($urandom_range(0, 2) != 0);
            inst_wr     = 1'($urandom);
            inst_size   = 2'($urandom);
            inst_wstrb  = 4'($urandom);
            inst_addr   = $urandom;
            inst_wdata  = $urandom;
            data_req    = ($urandom_range(0, 2) != 0);
            data_wr     = 1'($urandom);
            data_size   = 2'($urandom);
            data_wstrb  = 4'($urandom);
            data_addr   = $urandom;
            data_wdata  = $urandom;
            mem_addr_ok = 1'($urandom);
            mem_data_ok = ($urandom_range(0, 2) == 0);
            mem_rdata   = $urandom;
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
